// File: rtl/nibble_serial_add_sub_ctrl_pkg.sv
// rtl/nibble_serial_add_sub_ctrl_pkg.sv - shared FSM/op encodings for the nibble-serial add/sub block
package nibble_serial_add_sub_ctrl_pkg;

    // Controller states, 2-bit encoding; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Operation select encodings for the op input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Two's-complement overflow: both addend sign bits equal and the sum sign differs.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/nibble_serial_add_sub_ctrl_adder.sv
// rtl/nibble_serial_add_sub_ctrl_adder.sv - full-adder cell and 4-bit ripple adder with carry-in
//
// full_adder         : a, b, cin -> s, cout (one-bit cell)
// four_bit_adder_cin : a[3:0], b[3:0], cin -> s[3:0], cout (ripple of four full_adder cells)

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module four_bit_adder_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    // c[0] is the external carry-in, c[4] the carry out of bit 3.
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[4];
endmodule

// File: rtl/nibble_serial_add_sub_ctrl.sv
// rtl/nibble_serial_add_sub_ctrl.sv - nibble-serial W-bit add/subtract with valid/ready handshakes
//
// Parameter NIBBLES : operand width in nibbles (W = 4*NIBBLES), 1..8
// clk, rst_n        : rising-edge clock, asynchronous active-low reset
// in_valid/in_ready : request handshake carrying a, b (W bits) and op (0 add, 1 subtract)
// out_valid/out_ready : result handshake carrying result (W bits), cout, ovf
// busy              : high whenever the controller is not idle

module nibble_serial_add_sub_ctrl
    import nibble_serial_add_sub_ctrl_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t          state_q;
    state_t          state_d;

    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            op_q;
    logic            carry_q;
    logic [IW-1:0]   idx_q;
    logic [W-1:0]    result_q;
    logic            cout_q;
    logic            ovf_q;

    logic [3:0]      nib_a;
    logic [3:0]      nib_b;
    logic [3:0]      nib_b_eff;
    logic [3:0]      nib_sum;
    logic            nib_co;
    logic            last_nib;

    // Select the operand nibbles addressed by the running index.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    // Subtraction is A + ~B + 1; the +1 comes from the carry register preloaded with op.
    assign nib_b_eff = (op_q == OP_ADD) ? nib_b : ~nib_b;
    assign last_nib  = (idx_q == LAST_IDX);

    four_bit_adder_cin u_adder (
        .a    (nib_a),
        .b    (nib_b_eff),
        .cin  (carry_q),
        .s    (nib_sum),
        .cout (nib_co)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_CALC;
            ST_CALC: if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs depend on state only, never on the partner's valid/ready.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, nibble-serial accumulation and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        carry_q <= (op == OP_SUB);
                        idx_q   <= '0;
                    end
                end
                ST_CALC: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IW'(i)) begin
                            result_q[4*i +: 4] <= nib_sum;
                        end
                    end
                    carry_q <= nib_co;
                    if (last_nib) begin
                        idx_q  <= '0;
                        cout_q <= nib_co;
                        // nib_sum[3] is result[W-1] on the final nibble.
                        ovf_q  <= signed_ovf(a_q[W-1], nib_b_eff[3], nib_sum[3]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_sub_ctrl.sv
// tb/tb_nibble_serial_add_sub_ctrl.sv - scoreboard bench for nibble_serial_add_sub_ctrl
module tb_nibble_serial_add_sub_ctrl;

    localparam int NIBBLES = 2;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        int           acc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   rand_ready  = 1'b0;
    bit   ready_force = 1'b1;

    nibble_serial_add_sub_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mop);
        exp_t e;
        int ua, ub, full, sa, sbv, sr;
        ua   = int'(ma);
        ub   = int'(mb);
        full = mop ? (ua - ub + (1 << W)) : (ua + ub);
        e.r  = W'(full);
        e.c  = ((full >> W) & 1) != 0;
        sa   = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sbv  = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        sr   = mop ? (sa - sbv) : (sa + sbv);
        e.o  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        e.acc = 0;
        return e;
    endfunction

    // Issue one request starting at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic top,
                        input bit keep, input bit use_exp,
                        input logic [W-1:0] er, input logic ec, input logic eo,
                        output int acc_cyc);
        exp_t e;
        bit   done;
        done     = 1'b0;
        acc_cyc  = -1;
        a        = ta;
        b        = tb_b;
        op       = top;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                e = model(ta, tb_b, top);
                if (use_exp) begin
                    e.r = er;
                    e.c = ec;
                    e.o = eo;
                end
                e.acc   = cyc + 1;
                acc_cyc = e.acc;
                sb.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        if (!keep) in_valid = 1'b0;
    endtask

    // out_ready changes just after rising edges so the monitor sees it settled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_force;
        end
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
        bit           prev_ov;
        logic [W-1:0] hr;
        logic         hc, ho;
        exp_t         e;
        prev_ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else if (out_valid) begin
                if (!prev_ov) begin
                    hr = result;
                    hc = cout;
                    ho = ovf;
                    if (sb.size() == 0) begin
                        chk("spurious_out_valid", 32'd1, 32'd0);
                    end else begin
                        chk("latency", 32'(cyc - sb[0].acc), 32'(NIBBLES));
                    end
                end else begin
                    chk("hold_result", 32'(result), 32'(hr));
                    chk("hold_cout", 32'(cout), 32'(hc));
                    chk("hold_ovf", 32'(ovf), 32'(ho));
                end
                chk("in_ready_in_done", 32'(in_ready), 32'd0);
                chk("busy_in_done", 32'(busy), 32'd1);
                if (out_ready) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("result", 32'(result), 32'(e.r));
                        chk("cout", 32'(cout), 32'(e.c));
                        chk("ovf", 32'(ovf), 32'(e.o));
                    end
                    prev_ov = 1'b0;
                end else begin
                    prev_ov = 1'b1;
                end
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    initial begin
        int acc;
        int accs[5];
        bit done;

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        op       = 1'b0;
        #3;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // Directed arithmetic corners.
        send(8'h3C, 8'h45, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, acc);
        repeat (4) @(negedge clk);
        send(8'h10, 8'h01, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, acc);
        repeat (4) @(negedge clk);
        send(8'h00, 8'h01, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, acc);
        repeat (4) @(negedge clk);
        send(8'h80, 8'h01, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, acc);
        repeat (4) @(negedge clk);

        // Stall in DONE while the request side is disturbed.
        ready_force = 1'b0;
        repeat (2) @(negedge clk);
        send(8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (out_valid) done = 1'b1;
            else @(negedge clk);
        end
        chk("hold_reached_done", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a        = W'($urandom);
            b        = W'($urandom);
            op       = 1'($urandom_range(0, 1));
            in_valid = (i % 2) == 0;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid    = 1'b0;
        ready_force = 1'b1;
        repeat (6) @(negedge clk);
        chk("hold_drained", 32'(sb.size()), 32'd0);
        chk("hold_idle", 32'(busy), 32'd0);

        // Reset in the middle of a calculation.
        send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
        chk("abort_in_calc", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        send(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, acc);
        repeat (4) @(negedge clk);

        // Back-to-back throughput with in_valid held high.
        for (int i = 0; i < 5; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b0, '0, 1'b0, 1'b0, accs[i]);
        end
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("b2b_spacing", 32'(accs[i] - accs[i-1]), 32'(NIBBLES + 2));
        end
        repeat (6) @(negedge clk);

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("final_drain", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
